// File: rtl/bcd_disp8.sv
// bcd_disp8 -- binary-to-BCD display stage for the 8-bit register block.
// The upstream value is polled every clock. A change starts a sequential
// double-dabble conversion, one shift per clock, 8 clocks in total. The
// three BCD digits then drive a time-multiplexed 7-segment display with
// active-low segments and anodes.
// Optional build macro: BLANK_LEADING_ZERO_EN blanks the leading zero digits.
// With the macro undefined, all three digits are always lit.
module bcd_disp8 #(
   parameter int unsigned SCAN_DIV = 1000  // clocks per digit before the scan advances, >= 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in,
   output logic [11:0] bcd,
   output logic        busy,
   output logic [2:0]  an,
   output logic [6:0]  seg
);

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_CONV = 1'b1;

   // The prescaler needs at least one bit, even when SCAN_DIV == 1.
   localparam int unsigned   PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

   localparam logic [2:0] ITER_LAST = 3'd7;

   // ------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------
   // Double-dabble correction: a nibble of 5 or more gets +3 before the shift.
   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? (n + 4'd3) : n;
   endfunction

   // Active-low glyph decode, bit order {g,f,e,d,c,b,a}.
   // Codes 10..15 cannot occur and are shown blank.
   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'd0:    g = 7'b1000000;
         4'd1:    g = 7'b1111001;
         4'd2:    g = 7'b0100100;
         4'd3:    g = 7'b0110000;
         4'd4:    g = 7'b0011001;
         4'd5:    g = 7'b0010010;
         4'd6:    g = 7'b0000010;
         4'd7:    g = 7'b1111000;
         4'd8:    g = 7'b0000000;
         4'd9:    g = 7'b0010000;
         default: g = 7'b1111111;
      endcase
      return g;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [0:0]    state_q,    state_d;
   logic [7:0]    last_val_q, last_val_d;
   logic [19:0]   work_q,     work_d;      // {hundreds, tens, ones, binary}
   logic [2:0]    iter_q,     iter_d;
   logic [11:0]   bcd_q,      bcd_d;
   logic [PW-1:0] presc_q,    presc_d;
   logic [1:0]    idx_q,      idx_d;

   // Combinational intermediates for the conversion step
   logic [11:0] adj;
   logic [19:0] shifted;

   // ------------------------------------------------------------------
   // One double-dabble step: correct all three nibbles, then shift left.
   // ------------------------------------------------------------------
   always_comb begin
      adj     = {add3(work_q[19:16]), add3(work_q[15:12]), add3(work_q[11:8])};
      shifted = {adj[10:0], work_q[7:0], 1'b0};
   end

   // ------------------------------------------------------------------
   // Conversion FSM: poll for a changed input, then run 8 shift cycles.
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      last_val_d = last_val_q;
      work_d     = work_q;
      iter_d     = iter_q;
      bcd_d      = bcd_q;
      case (state_q)
         S_IDLE: begin
            if (in != last_val_q) begin
               work_d     = {12'h000, in};
               last_val_d = in;
               iter_d     = '0;
               state_d    = S_CONV;
            end
         end
         S_CONV: begin
            work_d = shifted;
            iter_d = iter_q + 3'd1;
            // bcd is only updated with the finished result, never a partial one.
            if (iter_q == ITER_LAST) begin
               bcd_d   = shifted[19:8];
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Scan timing: prescaler, then advance the digit index 0 -> 1 -> 2 -> 0.
   // This runs independently of the conversion.
   // ------------------------------------------------------------------
   always_comb begin
      presc_d = presc_q;
      idx_d   = idx_q;
      if (presc_q == PRESC_LAST) begin
         presc_d = '0;
         idx_d   = (idx_q == 2'd2) ? 2'd0 : (idx_q + 2'd1);
      end else begin
         presc_d = presc_q + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Registers: asynchronous active-low reset for all state.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         last_val_q <= '0;
         work_q     <= '0;
         iter_q     <= '0;
         bcd_q      <= '0;
         presc_q    <= '0;
         idx_q      <= '0;
      end else begin
         state_q    <= state_d;
         last_val_q <= last_val_d;
         work_q     <= work_d;
         iter_q     <= iter_d;
         bcd_q      <= bcd_d;
         presc_q    <= presc_d;
         idx_q      <= idx_d;
      end
   end

   // ------------------------------------------------------------------
   // Status outputs
   // ------------------------------------------------------------------
   assign bcd  = bcd_q;
   assign busy = (state_q == S_CONV);

   // ------------------------------------------------------------------
   // Display drive: anode select and segment decode, from registered state only.
   // ------------------------------------------------------------------
`ifdef BLANK_LEADING_ZERO_EN
   logic hund_zero;
   logic tens_zero;
   assign hund_zero = (bcd_q[11:8] == 4'd0);
   assign tens_zero = (bcd_q[7:4]  == 4'd0);
`endif

   always_comb begin
      an  = 3'b111;
      seg = 7'b1111111;
      case (idx_q)
         2'd0: begin
            an  = 3'b110;
            seg = glyph(bcd_q[3:0]);
         end
         2'd1: begin
            an  = 3'b101;
`ifdef BLANK_LEADING_ZERO_EN
            seg = (hund_zero && tens_zero) ? 7'b1111111 : glyph(bcd_q[7:4]);
`else
            seg = glyph(bcd_q[7:4]);
`endif
         end
         2'd2: begin
            an  = 3'b011;
`ifdef BLANK_LEADING_ZERO_EN
            seg = hund_zero ? 7'b1111111 : glyph(bcd_q[11:8]);
`else
            seg = glyph(bcd_q[11:8]);
`endif
         end
         default: begin
            an  = 3'b111;
            seg = 7'b1111111;
         end
      endcase
   end

endmodule

// File: tb/tb_bcd_disp8.sv
// tb_bcd_disp8 -- scoreboard bench for bcd_disp8.
// The stimulus pushes the expected BCD result of every conversion it starts.
// A monitor pops one entry each time busy falls and checks the conversion
// length. It also checks that bcd holds its value during a conversion.
// Reset and scan checks are made directly against hand-written constants.
module tb_bcd_disp8;

   localparam int unsigned SCAN_DIV = 4;

   logic        clk;
   logic        rst_n;
   logic [7:0]  in;
   logic [11:0] bcd;
   logic        busy;
   logic [2:0]  an;
   logic [6:0]  seg;

   int checks = 0;
   int errors = 0;

   logic [11:0] exp_q[$];

   bcd_disp8 #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in),
      .bcd   (bcd),
      .busy  (busy),
      .an    (an),
      .seg   (seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #2ms;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pop and compare when busy falls. Also check the busy length and that bcd is stable.
   logic        prev_busy = 1'b0;
   int          busy_len  = 0;
   logic [11:0] held_bcd  = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_busy = 1'b0;
         busy_len  = 0;
      end else begin
         if (busy && !prev_busy) begin
            busy_len = 0;
            held_bcd = bcd;
         end
         if (busy) begin
            busy_len++;
            if (bcd !== held_bcd) begin
               checks++;
               errors++;
               $display("FAIL bcd_hold: got %03h expected %03h during conversion", bcd, held_bcd);
            end
         end
         if (!busy && prev_busy) begin
            chk("busy_len", busy_len, 8);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got %03h expected none", bcd);
            end else begin
               chk("bcd_result", int'(bcd), int'(exp_q.pop_front()));
            end
         end
         prev_busy = busy;
      end
   end

   // Wait until every pushed result has been popped and busy is low, within a bound.
   task automatic wait_done(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got queue=%0d expected 0", name, exp_q.size());
      end
   endtask

   // Scan sweep: align on an becoming 110, then check 12 cycles of an and seg.
   task automatic scan_check(input string name, input logic [6:0] s0,
                             input logic [6:0] s1, input logic [6:0] s2);
      logic [2:0] exp_an[3];
      logic [6:0] exp_seg[3];
      logic [2:0] last_an;
      int n = 0;
      exp_an[0] = 3'b110; exp_an[1] = 3'b101; exp_an[2] = 3'b011;
      exp_seg[0] = s0;    exp_seg[1] = s1;    exp_seg[2] = s2;
      @(negedge clk);
      last_an = an;
      @(negedge clk);
      while (!(an == 3'b110 && last_an != 3'b110) && n < 50) begin
         last_an = an;
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL %s_align: got an=%03b expected 110", name, an);
      end
      for (int k = 0; k < 12; k++) begin
         chk({name, "_an"}, int'(an), int'(exp_an[k / 4]));
         chk({name, "_seg"}, int'(seg), int'(exp_seg[k / 4]));
         @(negedge clk);
      end
   endtask

   localparam logic [6:0] G0 = 7'b1000000;
   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] G2 = 7'b0100100;
   localparam logic [6:0] G3 = 7'b0110000;
   localparam logic [6:0] G7 = 7'b1111000;
   localparam logic [6:0] GB = 7'b1111111;

   logic [11:0] step_exp[11];

   initial begin
      step_exp = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005,
                   12'h006, 12'h007, 12'h008, 12'h009, 12'h010};

      // 1: reset state, no conversion while the input stays 0
      rst_n = 1'b0;
      in    = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst_bcd_low", int'(bcd), 0);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst_bcd", int'(bcd), 0);
         chk("rst_busy", int'(busy), 0);
      end
      // Check before the first scan advance, while the index is still 0.
      rst_n = 1'b0;
      #1;
      chk("rst_an", int'(an), 3'b110);
      chk("rst_seg", int'(seg), 7'b1000000);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // 2: in = 255
      in = 8'd255;
      exp_q.push_back(12'h255);
      @(negedge clk);
      chk("busy_start", int'(busy), 1);
      chk("bcd_before", int'(bcd), 0);
      wait_done("t255");

      // 3: step 0 -> 10
      for (int v = 0; v <= 10; v++) begin
         in = 8'(v);
         exp_q.push_back(step_exp[v]);
         repeat (20) @(negedge clk);
      end
      wait_done("steps");
      chk("step_final", int'(bcd), 12'h010);

      // 4: input change during a conversion
      in = 8'd100;
      exp_q.push_back(12'h100);
      repeat (4) @(negedge clk);
      in = 8'd42;
      exp_q.push_back(12'h042);
      wait_done("mid_change");
      chk("mid_final", int'(bcd), 12'h042);

      // 5: scan of 123
      in = 8'd123;
      exp_q.push_back(12'h123);
      wait_done("t123");
      scan_check("scan123", G3, G2, G1);

      // 6: in = 7, leading zeros
      in = 8'd7;
      exp_q.push_back(12'h007);
      wait_done("t7");
`ifdef BLANK_LEADING_ZERO_EN
      scan_check("scan7", G7, GB, GB);
`else
      scan_check("scan7", G7, G0, G0);
`endif

      // Reset in the middle of a conversion
      in = 8'd200;
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_bcd", int'(bcd), 0);
      chk("abort_an", int'(an), 3'b110);
      chk("abort_seg", int'(seg), 7'b1000000);
      @(negedge clk);
      exp_q.push_back(12'h200);
      #2 rst_n = 1'b1;
      wait_done("after_rst");
      chk("after_rst_bcd", int'(bcd), 12'h200);

      repeat (2) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
